mem_io_tdp: RTL and testbench

Parametrised two-port memory front end: wraps one true-dual-port block RAM and gives each port independent valid/ready request channels, a configurable-latency read pipeline, and tagged read responses that carry the originating address. It sits between the fetch/load-store units and on-chip RAM. It generalises the fixed 32-bit, 3-cycle memory interface with these additions:

- parametrised width, depth and latency
- out-of-range error reporting
- per-port in-flight tracking
- optional cross-port collision arbitration

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/tdp_bram_rf.sv | 32 +++
 rtl/mem_io_tdp.sv | 184 ++++++++++++++++++
 tb/tb_mem_io_tdp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the mem_io_tdp two-port memory front end.
// Holds the read-response tag layout and the byte-address to word-index helper.
package mem_io_pkg;

  localparam int MAX_RD_LAT = 8;
  localparam int TAG_ADDR_W = 64;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] addr;
    logic                  err;
  } rsp_tag_t;

  function automatic logic [TAG_ADDR_W-1:0] word_index(input logic [TAG_ADDR_W-1:0] addr,
                                                       input int unsigned            off_w);
    return addr >> off_w;
  endfunction

endpackage

// File: rtl/tdp_bram_rf.sv
// Inferred true-dual-port RAM with per-byte write enables, READ_FIRST behaviour
// and a single registered read stage on each port.
module tdp_bram_rf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [BE_W-1:0]   a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [BE_W-1:0]   b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // p0: both ports read the pre-write contents, then apply their byte lanes
  always_ff @(posedge clk) begin
    a_rdata <= mem[a_idx];
    b_rdata <= mem[b_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (a_we[i]) mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
      if (b_we[i]) mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_io_tdp.sv
// Two-port valid/ready memory front end over tdp_bram_rf with tagged, fixed-latency
// read responses. Optional cross-port collision arbitration: MEM_IO_COLLISION_CHECK_EN.
module mem_io_tdp
  import mem_io_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 3,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  input  logic [BE_W-1:0]   a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rd_ready,
  output logic              a_wr_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  output logic [ADDR_W-1:0] a_rsp_addr,
  output logic              a_rsp_err,
  output logic [3:0]        a_inflight,
  input  logic              b_req_valid,
  input  logic [BE_W-1:0]   b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rd_ready,
  output logic              b_wr_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [ADDR_W-1:0] b_rsp_addr,
  output logic              b_rsp_err,
  output logic [3:0]        b_inflight,
  output logic              collision
);

  localparam int LAT   = (RD_LAT < 1) ? 1 : ((RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT);
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  logic                  req_vld   [2];
  logic [BE_W-1:0]       req_we    [2];
  logic [ADDR_W-1:0]     req_addr  [2];
  logic [DATA_W-1:0]     req_wdata [2];
  logic [TAG_ADDR_W-1:0] widx      [2];
  logic                  in_rng    [2];
  logic                  rd_acc    [2];
  logic                  wr_acc    [2];
  logic                  wr_rdy    [2];
  logic [3:0]            infl      [2];
  logic [IDX_W-1:0]      ram_idx   [2];
  logic [BE_W-1:0]       ram_we    [2];
  logic [DATA_W-1:0]     ram_q     [2];
  logic                  rsp_vld   [2];
  logic                  rsp_err   [2];
  logic [ADDR_W-1:0]     rsp_addr  [2];
  logic [DATA_W-1:0]     rsp_rdata [2];
  logic                  supp_b;

  assign req_vld[0]   = a_req_valid;
  assign req_we[0]    = a_req_we;
  assign req_addr[0]  = a_req_addr;
  assign req_wdata[0] = a_req_wdata;
  assign req_vld[1]   = b_req_valid;
  assign req_we[1]    = b_req_we;
  assign req_addr[1]  = b_req_addr;
  assign req_wdata[1] = b_req_wdata;

  assign a_rd_ready  = ~rst;
  assign b_rd_ready  = ~rst;
  assign a_wr_ready  = wr_rdy[0];
  assign b_wr_ready  = wr_rdy[1];
  assign a_rsp_valid = rsp_vld[0];
  assign b_rsp_valid = rsp_vld[1];
  assign a_rsp_err   = rsp_err[0];
  assign b_rsp_err   = rsp_err[1];
  assign a_rsp_addr  = rsp_addr[0];
  assign b_rsp_addr  = rsp_addr[1];
  assign a_rsp_rdata = rsp_rdata[0];
  assign b_rsp_rdata = rsp_rdata[1];
  assign a_inflight  = infl[0];
  assign b_inflight  = infl[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    rsp_tag_t          tag_p [LAT];
    logic [DATA_W-1:0] dat_p0;
    logic [3:0]        cnt;
    logic              suppress;
    logic              unused_tag_hi;

    assign widx[p]    = word_index(TAG_ADDR_W'(req_addr[p]), OFF_W);
    assign in_rng[p]  = widx[p] < TAG_ADDR_W'(DEPTH);
    assign wr_rdy[p]  = ~rst & (infl[p] == 4'd0);
    assign rd_acc[p]  = req_vld[p] & (req_we[p] == '0) & ~rst;
    assign wr_acc[p]  = req_vld[p] & (req_we[p] != '0) & wr_rdy[p];
    assign suppress   = (p == 1) ? supp_b : 1'b0;
    assign ram_idx[p] = widx[p][IDX_W-1:0];
    // Out-of-range and losing colliding writes still count as accepted but never reach the RAM
    assign ram_we[p]  = (wr_acc[p] & in_rng[p] & ~suppress) ? req_we[p] : '0;

    // The stage being answered this cycle no longer counts as outstanding
    always_comb begin
      cnt = 4'd0;
      for (int k = 0; k < LAT - 1; k++) cnt = cnt + {3'b000, tag_p[k].valid};
    end
    assign infl[p] = cnt;

    // p0: tag captured in step with the RAM read register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < LAT; k++) tag_p[k] <= '0;
      end else begin
        tag_p[0] <= '{valid: rd_acc[p],
                      addr:  rd_acc[p] ? TAG_ADDR_W'(req_addr[p]) : '0,
                      err:   rd_acc[p] & ~in_rng[p]};
        for (int k = 1; k < LAT; k++) tag_p[k] <= tag_p[k-1];
      end
    end

    assign dat_p0 = (tag_p[0].valid & ~tag_p[0].err) ? ram_q[p] : '0;

    if (LAT == 1) begin : g_lat1
      assign rsp_rdata[p] = dat_p0;
    end else begin : g_latn
      logic [DATA_W-1:0] dat_p [LAT-1];

      // p1..pN: output register stages aligned with the tag shift register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LAT - 1; k++) dat_p[k] <= '0;
        end else begin
          dat_p[0] <= dat_p0;
          for (int k = 1; k < LAT - 1; k++) dat_p[k] <= dat_p[k-1];
        end
      end
      assign rsp_rdata[p] = dat_p[LAT-2];
    end

    assign rsp_vld[p]    = tag_p[LAT-1].valid;
    assign rsp_err[p]    = tag_p[LAT-1].err;
    assign rsp_addr[p]   = tag_p[LAT-1].addr[ADDR_W-1:0];
    // Tag addresses are zero-extended, so the bits above ADDR_W carry nothing
    assign unused_tag_hi = ^tag_p[LAT-1].addr[TAG_ADDR_W-1:ADDR_W];
  end

  tdp_bram_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .a_idx   (ram_idx[0]),
    .a_we    (ram_we[0]),
    .a_wdata (req_wdata[0]),
    .a_rdata (ram_q[0]),
    .b_idx   (ram_idx[1]),
    .b_we    (ram_we[1]),
    .b_wdata (req_wdata[1]),
    .b_rdata (ram_q[1])
  );

`ifdef MEM_IO_COLLISION_CHECK_EN
  logic same_idx;
  logic ww_hit;
  logic rw_hit;
  logic coll_q;

  assign same_idx = in_rng[0] & in_rng[1] & (widx[0] == widx[1]);
  assign ww_hit   = same_idx & wr_acc[0] & wr_acc[1];
  assign rw_hit   = same_idx & ((rd_acc[0] & wr_acc[1]) | (wr_acc[0] & rd_acc[1]));
  assign supp_b   = ww_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_q <= 1'b0;
    else if (ww_hit | rw_hit) coll_q <= 1'b1;
  end
  assign collision = coll_q;
`else
  assign supp_b    = 1'b0;
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_tdp.sv
// Directed bench for mem_io_tdp (DATA_W=32, DEPTH=4096, RD_LAT=3).
// Expected collision behaviour follows MEM_IO_COLLISION_CHECK_EN.
module tb_mem_io_tdp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0;
  logic [3:0]  a_req_we = '0;
  logic [31:0] a_req_addr = '0;
  logic [31:0] a_req_wdata = '0;
  logic        a_rd_ready, a_wr_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata, a_rsp_addr;
  logic [3:0]  a_inflight;
  logic        b_req_valid = 1'b0;
  logic [3:0]  b_req_we = '0;
  logic [31:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_rd_ready, b_wr_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata, b_rsp_addr;
  logic [3:0]  b_inflight;
  logic        collision;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_io_tdp #(.ADDR_W(32), .DATA_W(32), .DEPTH(4096), .RD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_rd_ready(a_rd_ready), .a_wr_ready(a_wr_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata), .a_rsp_addr(a_rsp_addr),
    .a_rsp_err(a_rsp_err), .a_inflight(a_inflight),
    .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_rd_ready(b_rd_ready), .b_wr_ready(b_wr_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata), .b_rsp_addr(b_rsp_addr),
    .b_rsp_err(b_rsp_err), .b_inflight(b_inflight),
    .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    a_req_valid = 1'b0; a_req_we = '0;
    b_req_valid = 1'b0; b_req_we = '0;
  endtask

  task automatic wr(input bit p, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] we);
    if (p == 1'b0) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = data;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
    end
    step();
    clear_reqs();
  endtask

  // Issues one read and waits (bounded) for its response; lat counts edges from accept.
  task automatic rd(input bit p, input logic [31:0] addr, output logic [31:0] data,
                    output logic [31:0] raddr, output logic err, output int lat);
    if (p == 1'b0) begin
      a_req_valid = 1'b1; a_req_we = '0; a_req_addr = addr;
    end else begin
      b_req_valid = 1'b1; b_req_we = '0; b_req_addr = addr;
    end
    step();
    clear_reqs();
    lat = 1;
    while (((p == 1'b0) ? a_rsp_valid : b_rsp_valid) !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    data  = (p == 1'b0) ? a_rsp_rdata : b_rsp_rdata;
    raddr = (p == 1'b0) ? a_rsp_addr  : b_rsp_addr;
    err   = (p == 1'b0) ? a_rsp_err   : b_rsp_err;
  endtask

  task automatic test_reset();
    step(); step();
    tests_run++;
    if ({a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0000",
               {a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready});
    end
    tests_run++;
    if ({a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err, collision} !== 5'b0 ||
        a_inflight !== 4'd0 || b_inflight !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got vld/err/coll %b infl %0d/%0d expected 0",
               {a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err, collision}, a_inflight, b_inflight);
    end
    tests_run++;
    if (a_rsp_rdata !== 32'h0 || a_rsp_addr !== 32'h0 || b_rsp_rdata !== 32'h0 || b_rsp_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h expected 0", a_rsp_rdata, a_rsp_addr, b_rsp_rdata, b_rsp_addr);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL release_ready: got %b expected 1111",
               {a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready});
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d, ad;
    logic        e;
    int          lat;
    wr(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd(1'b0, 32'h10, d, ad, e, lat);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL wr_rd_latency: got %0d expected 3", lat);
    end
    tests_run++;
    if (d !== 32'hDEADBEEF || ad !== 32'h10 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rd_rsp: got data %h addr %h err %b expected deadbeef 00000010 0", d, ad, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hA4A4A4A4; exp_d[2] = 32'hA8A8A8A8;
    for (int i = 0; i < 3; i++) wr(1'b0, 32'(i * 4), exp_d[i], 4'hF);
    for (int e = 1; e <= 6; e++) begin
      if (e <= 3) begin
        a_req_valid = 1'b1; a_req_we = '0; a_req_addr = 32'((e - 1) * 4);
      end else begin
        clear_reqs();
      end
      step();
      tests_run++;
      if (a_rsp_valid !== (e >= 3 && e <= 5)) begin
        tests_failed++;
        $display("FAIL b2b_valid edge %0d: got %b expected %b", e, a_rsp_valid, (e >= 3 && e <= 5));
      end else if (e >= 3 && e <= 5) begin
        tests_run++;
        if (a_rsp_rdata !== exp_d[e-3] || a_rsp_addr !== 32'((e - 3) * 4)) begin
          tests_failed++;
          $display("FAIL b2b_data edge %0d: got %h @%h expected %h @%h", e, a_rsp_rdata, a_rsp_addr,
                   exp_d[e-3], 32'((e - 3) * 4));
        end
      end
      tests_run++;
      if (a_wr_ready !== (e >= 5)) begin
        tests_failed++;
        $display("FAIL b2b_wr_ready edge %0d: got %b expected %b", e, a_wr_ready, (e >= 5));
      end
      if (e == 3) begin
        tests_run++;
        if (a_inflight !== 4'd2) begin
          tests_failed++;
          $display("FAIL b2b_inflight: got %0d expected 2", a_inflight);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d, ad;
    logic        e;
    int          lat;
    wr(1'b0, 32'h20, 32'h11223344, 4'hF);
    wr(1'b0, 32'h20, 32'h0000AA00, 4'h2);
    rd(1'b1, 32'h20, d, ad, e, lat);
    tests_run++;
    if (d !== 32'h1122AA44 || lat !== 3 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL byte_enable: got %h lat %0d err %b expected 1122aa44 lat 3 err 0", d, lat, e);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d, ad;
    logic        e;
    int          lat;
    rd(1'b1, 32'h4000, d, ad, e, lat);
    tests_run++;
    if (d !== 32'h0 || e !== 1'b1 || ad !== 32'h4000 || lat !== 3) begin
      tests_failed++;
      $display("FAIL oor_read: got data %h err %b addr %h lat %0d expected 0 1 00004000 3", d, e, ad, lat);
    end
    tests_run++;
    if (a_wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_wr_ready: got %b expected 1", a_wr_ready);
    end
    wr(1'b0, 32'h4000, 32'hFFFFFFFF, 4'hF);
    rd(1'b0, 32'h0, d, ad, e, lat);
    tests_run++;
    if (d !== 32'hA0A0A0A0 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_write_dropped: got %h err %b expected a0a0a0a0 0", d, e);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d, ad;
    logic        e, exp_coll;
    int          lat;
`ifdef MEM_IO_COLLISION_CHECK_EN
    exp_coll = 1'b1;
`else
    exp_coll = 1'b0;
`endif
    a_req_valid = 1'b1; a_req_we = 4'hF; a_req_addr = 32'h30; a_req_wdata = 32'h1;
    b_req_valid = 1'b1; b_req_we = 4'hF; b_req_addr = 32'h30; b_req_wdata = 32'h2;
    step();
    clear_reqs();
    tests_run++;
    if (collision !== exp_coll) begin
      tests_failed++;
      $display("FAIL collision_flag: got %b expected %b", collision, exp_coll);
    end
    rd(1'b0, 32'h30, d, ad, e, lat);
    if (exp_coll) begin
      tests_run++;
      if (d !== 32'h1) begin
        tests_failed++;
        $display("FAIL collision_a_wins: got %h expected 00000001", d);
      end
    end
    wr(1'b1, 32'h34, 32'h5, 4'hF);
    a_req_valid = 1'b1; a_req_we = '0; a_req_addr = 32'h34;
    b_req_valid = 1'b1; b_req_we = 4'hF; b_req_addr = 32'h34; b_req_wdata = 32'h6;
    step();
    clear_reqs();
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    tests_run++;
    if (a_rsp_rdata !== 32'h5 || lat !== 3) begin
      tests_failed++;
      $display("FAIL cross_read_first: got %h lat %0d expected 00000005 lat 3", a_rsp_rdata, lat);
    end
    rd(1'b1, 32'h34, d, ad, e, lat);
    tests_run++;
    if (d !== 32'h6 || collision !== exp_coll) begin
      tests_failed++;
      $display("FAIL cross_write_lands: got %h coll %b expected 00000006 coll %b", d, collision, exp_coll);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d, ad;
    logic        e;
    int          lat, seen;
    a_req_valid = 1'b1; a_req_we = '0; a_req_addr = 32'h10;
    step(); step();
    clear_reqs();
    tests_run++;
    if (a_inflight !== 4'd2) begin
      tests_failed++;
      $display("FAIL midflight_inflight: got %0d expected 2", a_inflight);
    end
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_we = 4'hF; a_req_addr = 32'h10; a_req_wdata = 32'hBAD0BAD0;
    #1;
    tests_run++;
    if (a_inflight !== 4'd0 || a_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_async_clear: got infl %0d vld %b expected 0 0", a_inflight, a_rsp_valid);
    end
    step(); step();
    clear_reqs();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_rsp_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen !== 0 || a_inflight !== 4'd0) begin
      tests_failed++;
      $display("FAIL midflight_no_rsp: got %0d responses infl %0d expected 0 0", seen, a_inflight);
    end
    rd(1'b0, 32'h10, d, ad, e, lat);
    tests_run++;
    if (d !== 32'hDEADBEEF || lat !== 3) begin
      tests_failed++;
      $display("FAIL midflight_ram_kept: got %h lat %0d expected deadbeef lat 3", d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_byte_enable();
    test_out_of_range();
    test_collision();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
